// File: rtl/y_window_pkg.sv
// Shared definitions for the separable 5x5 Gaussian stages: default coefficients,
// pixel width, divide shift and the tap/product bundles passed between pipeline stages.
package y_window_pkg;

  localparam int unsigned PIX_W     = 8;
  localparam int unsigned PROD_W    = 16;
  localparam int unsigned DIV_SHIFT = 8;

  localparam int unsigned H0_DEF = 6;
  localparam int unsigned H1_DEF = 58;
  localparam int unsigned H2_DEF = 128;

  // Rows 0..3 have no full vertical window; row counter saturates here.
  localparam logic [2:0] ROW_FULL = 3'd4;

  typedef logic [PIX_W-1:0] pix_t;

  typedef struct packed {
    pix_t t4;
    pix_t t3;
    pix_t t2;
    pix_t t1;
    pix_t t0;
  } taps_t;

  typedef struct packed {
    logic [PROD_W-1:0] p2;
    logic [PROD_W-1:0] p1;
    logic [PROD_W-1:0] p0;
  } prods_t;

  function automatic logic [PIX_W:0] pair_sum(input pix_t a, input pix_t b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/line_delay.sv
// One image line of delay: single-port RAM read before write at a wrapping address.
// The old entry is presented combinationally while the new pixel is written on en.
module line_delay
  import y_window_pkg::*;
#(
  parameter int unsigned WIDTH = 640,
  parameter int unsigned CW    = 10
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic [PIX_W-1:0] din,
  output logic [PIX_W-1:0] dout
);

  localparam logic [CW-1:0] ADDR_LAST = CW'(WIDTH - 1);

  pix_t          mem [WIDTH];
  logic [CW-1:0] addr_q, addr_d;

  always_comb begin
    addr_d = addr_q;
    if (en) begin
      addr_d = (addr_q == ADDR_LAST) ? '0 : addr_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  // Contents are never cleared; stale data only reaches dout while validout is low.
  always_ff @(posedge clock) begin
    if (en) begin
      mem[addr_q] <= din;
    end
  end

  assign dout = mem[addr_q];

endmodule

// File: rtl/y_window.sv
// Vertical 5-tap Gaussian [h0 h1 h2 h1 h0]/256 over a raster pixel stream,
// four line delays feeding a three-register pipeline that advances only on validin.
module y_window
  import y_window_pkg::*;
#(
  parameter int unsigned h0    = H0_DEF,
  parameter int unsigned h1    = H1_DEF,
  parameter int unsigned h2    = H2_DEF,
  parameter int unsigned WIDTH = 640,
  parameter int unsigned CW    = 10
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [PIX_W-1:0] din,
  input  logic             validin,
  output logic [PIX_W-1:0] dout,
  output logic             validout
);

  localparam logic [CW-1:0]     COL_LAST = CW'(WIDTH - 1);
  localparam logic [PROD_W-1:0] C0       = PROD_W'(h0);
  localparam logic [PROD_W-1:0] C1       = PROD_W'(h1);
  localparam logic [PROD_W-1:0] C2       = PROD_W'(h2);

  logic [CW-1:0] col_q, col_d;
  logic [2:0]    row_q, row_d;
  taps_t         taps_q, taps_d;
  prods_t        prods_q, prods_d;
  pix_t          out_q, out_d;
  logic [2:0]    vld_q, vld_d;
  logic [16:0]   sum;

  pix_t ld_in  [4];
  pix_t ld_out [4];

  assign ld_in[0] = din;
  assign ld_in[1] = ld_out[0];
  assign ld_in[2] = ld_out[1];
  assign ld_in[3] = ld_out[2];

  for (genvar k = 0; k < 4; k++) begin : g_line
    line_delay #(
      .WIDTH (WIDTH),
      .CW    (CW)
    ) u_line_delay (
      .clock (clock),
      .reset (reset),
      .en    (validin),
      .din   (ld_in[k]),
      .dout  (ld_out[k])
    );
  end

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (validin) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        if (row_q != ROW_FULL) begin
          row_d = row_q + 3'd1;
        end
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_comb begin
    taps_d = '{t4: din, t3: ld_out[0], t2: ld_out[1], t1: ld_out[2], t0: ld_out[3]};

    prods_d.p0 = C0 * PROD_W'(pair_sum(taps_q.t0, taps_q.t4));
    prods_d.p1 = C1 * PROD_W'(pair_sum(taps_q.t1, taps_q.t3));
    prods_d.p2 = C2 * PROD_W'(taps_q.t2);

    // Coefficients sum to 256, so the 17-bit sum never sets bit 16; truncate, no rounding.
    sum   = 17'(prods_q.p0) + 17'(prods_q.p1) + 17'(prods_q.p2);
    out_d = PIX_W'(sum >> DIV_SHIFT);

    vld_d = {vld_q[1:0], (row_q == ROW_FULL)};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      col_q   <= '0;
      row_q   <= '0;
      taps_q  <= '0;
      prods_q <= '0;
      out_q   <= '0;
      vld_q   <= '0;
    end else if (validin) begin
      col_q   <= col_d;
      row_q   <= row_d;
      taps_q  <= taps_d;
      prods_q <= prods_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
    end
  end

  assign dout     = out_q;
  assign validout = validin & vld_q[2];

endmodule

// File: doc/y_window.md
Name: y_window

Overview:
- Vertical 5-tap Gaussian smoothing stage on a raster-order 8-bit pixel stream.
- Sits directly downstream of the horizontal 5-tap stage and consumes its dout/validout, so the two stages together form a separable 5x5 Gaussian.
- Holds the previous four image lines in cascaded line delays.
- Filters each column with kernel [h0 h1 h2 h1 h0]/256.

Parameters:
- h0, 6: outer tap coefficient (rows r-4 and r).
- h1, 58: inner tap coefficient (rows r-3 and r-1).
- h2, 128: centre tap coefficient (row r-2). Required: 2*h0 + 2*h1 + h2 = 256.
- WIDTH, 640: pixels per image line; must be ≥ 4.
- CW, 10: column counter width; must satisfy 2^CW ≥ WIDTH.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- din  in  8  pixel from upstream horizontal stage.
- validin  in  1  din valid; the whole block advances only when high.
- dout  out  8  filtered pixel.
- validout  out  1  dout valid for this beat.

Behaviour:
- Reset (reset low, asynchronous): clears col, row_cnt, all pipeline registers, the valid shift bits and OUT.
  - dout = 0 and validout = 0 while reset is low.
  - Line-delay contents are don't-care and need not be cleared.
- Stall: when validin is low, no state changes at all. Gaps of any length are transparent.
- Column counter col:
  - Increments on each validin beat.
  - At WIDTH-1 it wraps to 0 and row_cnt increments.
  - row_cnt is 3 bits and saturates at 4.
  - No frame marker exists; a new frame requires reset.
- Line delays:
  - Four WIDTH-deep, 8-bit delay lines chained din -> L0 -> L1 -> L2 -> L3, each advancing on validin.
  - While pixel (r,c) is on din, Lk presents pixel (r-k-1, c).
  - Read of the old entry precedes the write of the new one at the same address.
- Pipeline: three registers, each advancing only on validin.
  - S1 captures taps t4 = din, t3 = L0, t2 = L1, t1 = L2, t0 = L3.
  - S2 computes p0 = h0*(t0+t4), p1 = h1*(t1+t3), p2 = h2*t2. Each product is ≤ 16 bits (the pair sum of two 8-bit values is 9 bits).
  - OUT register takes the high byte sum[15:8] of sum = p0 + p1 + p2. Sum width is 17 bits; the maximum is 65280, so bit 16 is always 0.
  - Truncation only, no rounding.
- Latency: the window whose newest pixel is accepted on validin beat n appears on dout after beat n+3. That window is centred on row r-2, column c.
- Valid tracking:
  - A 3-bit shift register advances on validin.
  - Its input bit = (row_cnt == 4) at the moment the pixel is accepted, i.e. the current row index ≥ 4.
  - validout = validin AND msb of the shift register, combinational with validin, matching the upstream stage's convention.
- Boundaries:
  - Rows 0..3 produce no validout.
  - No border padding: output frame is H-4 rows by WIDTH columns.
  - Column wrap uses no horizontal context, so no edge handling is required.
  - Reset asserted mid-line discards all partial state; the next accepted pixel is row 0, column 0.

Decomposition:
- Shared package: default Gaussian coefficients (6/58/128), divide shift of 8, pixel width 8. The upstream horizontal stage uses the same package.
- One sub-module: line_delay.
  - Parameters: WIDTH and CW.
  - Ports: clock, reset, en, din[7:0], dout[7:0].
  - Single-port RAM with read-before-write plus an address counter; four instances.

Test Plan:
- Reset and stall: WIDTH=8, hold reset low for 3 cycles, then 40 validin beats with every 3rd beat gapped.
  - Required: validout = 0 throughout.
  - Required: dout = 0 during reset.
  - Required: state does not change across gaps.
- Flat image: WIDTH=8, 6 rows of constant 100 (48 beats).
  - Required: 13 validout beats, each with dout = 100 (25600>>8).
- Impulse: WIDTH=8, single pixel 255 at row 4, column 3, all else 0, 9 rows.
  - Required: column-3 outputs for centre rows 2..6 are 5, 57, 127, 57, 5.
  - Required: all other outputs are 0.
- Saturation: all pixels 255.
  - Required: dout = 255 (65280>>8), with no overflow.
- Row-gradient: row r pixels = 10*r, WIDTH=8.
  - Required: output centred on row 2 = floor((6*0 + 58*10 + 128*20 + 58*30 + 6*40)/256) = floor(5120/256) = 20.
- Mid-line reset: reset pulse during row 5, column 4, then a fresh flat-100 image.
  - Required: no validout for the next 4 rows plus 3 beats.
  - Required: values are correct thereafter.
